// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared sequential 8x8 multiplier.
// Round-robin on ties, one transaction in flight, timeout abort on a stuck multiplier.
module mult_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic [1:0]  req,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ack,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        mul_start,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_product,
    output logic        err_flag,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StAbort} state_e;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_e     state;
    logic       owner;
    logic       last_served;
    logic [7:0] timer;
    logic       winner;

    // On a tie the requester that was not served last wins.
    always_comb begin
        winner = 1'b0;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_served;
            default: winner = 1'b0;
        endcase
    end

    // rsp_data doubles as the result register; it reads 0 whenever no response is pending.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state       <= StIdle;
            owner       <= 1'b0;
            last_served <= 1'b1;
            timer       <= 8'd0;
            gnt         <= 2'b00;
            rsp_valid   <= 2'b00;
            rsp_data    <= 16'd0;
            rsp_err     <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= 8'd0;
            mul_b       <= 8'd0;
            err_flag    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req != 2'b00) begin
                        owner     <= winner;
                        mul_a     <= winner ? a1 : a0;
                        mul_b     <= winner ? b1 : b0;
                        gnt       <= winner ? 2'b10 : 2'b01;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    gnt       <= 2'b00;
                    mul_start <= 1'b0;
                    timer     <= 8'd0;
                    state     <= StWait;
                end
                StWait: begin
                    if (mul_done) begin
                        rsp_data  <= mul_product;
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        rsp_err   <= 1'b0;
                        state     <= StResp;
                    end else begin
                        timer <= timer + 8'd1;
                        if (timer == TimerLast) begin
                            rsp_data  <= 16'd0;
                            rsp_valid <= owner ? 2'b10 : 2'b01;
                            rsp_err   <= 1'b1;
                            err_flag  <= 1'b1;
                            state     <= StAbort;
                        end
                    end
                end
                StResp, StAbort: begin
                    if (rsp_ack[owner]) begin
                        rsp_valid   <= 2'b00;
                        rsp_err     <= 1'b0;
                        rsp_data    <= 16'd0;
                        last_served <= owner;
                        busy        <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: transaction-level model checked every cycle,
// plus literal expectations for grants, products, latencies and reset behaviour.
module tb_mult_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset_a;
    logic [1:0]  req;
    logic [7:0]  a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ack;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        mul_start;
    logic [7:0]  mul_a, mul_b;
    logic        mul_done = 1'b0;
    logic [15:0] mul_product = 16'd0;
    logic        err_flag;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    mult_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_a    (reset_a),
        .req        (req),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ack    (rsp_ack),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_product(mul_product),
        .err_flag   (err_flag),
        .busy       (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Multiplier stand-in: done mdelay cycles after start (0 = never), optional stray done.
    int          mdelay = 5;
    int          mcnt = 0;
    logic [15:0] mprod = 16'd0;
    int          spur_req = 0;
    int          spur_ack = 0;

    always @(negedge clk) begin
        mul_done <= 1'b0;
        if (reset_a) begin
            mcnt <= 0;
        end else if (mul_start) begin
            mprod <= {8'h00, mul_a} * {8'h00, mul_b};
            mcnt  <= mdelay;
        end else if (mcnt == 1) begin
            mcnt        <= 0;
            mul_done    <= 1'b1;
            mul_product <= mprod;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (spur_req != spur_ack && rsp_valid != 2'b00) begin
            spur_ack    <= spur_req;
            mul_done    <= 1'b1;
            mul_product <= 16'hBEEF;
        end
    end

    // Transaction model: ph 0 idle, 1 granted, 2 multiplying, 3 responding.
    int          ph = 0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    int          m_wait = 0;
    logic [7:0]  m_a = 8'd0, m_b = 8'd0;
    logic [15:0] m_data = 16'd0;
    bit          m_err = 1'b0;
    bit          m_flag = 1'b0;

    function automatic bit pick(input logic [1:0] r, input bit last);
        return (r == 2'b11) ? ~last : r[1];
    endfunction

    always @(posedge clk) begin
        if (reset_a) begin
            ph     <= 0;
            m_last <= 1'b1;
            m_flag <= 1'b0;
        end else begin
            case (ph)
                0: if (req != 2'b00) begin
                    m_owner <= pick(req, m_last);
                    m_a     <= pick(req, m_last) ? a1 : a0;
                    m_b     <= pick(req, m_last) ? b1 : b0;
                    ph      <= 1;
                end
                1: begin
                    m_wait <= 0;
                    ph     <= 2;
                end
                2: if (mul_done) begin
                    m_data <= {8'h00, m_a} * {8'h00, m_b};
                    m_err  <= 1'b0;
                    ph     <= 3;
                end else begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 == int'(TO)) begin
                        m_data <= 16'd0;
                        m_err  <= 1'b1;
                        m_flag <= 1'b1;
                        ph     <= 3;
                    end
                end
                default: if (rsp_ack[m_owner]) begin
                    m_last <= m_owner;
                    ph     <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", gnt, (ph == 1) ? (m_owner ? 2 : 1) : 0);
            check("mul_start", mul_start, ph == 1);
            check("rsp_valid", rsp_valid, (ph == 3) ? (m_owner ? 2 : 1) : 0);
            check("rsp_err", rsp_err, ph == 3 && m_err);
            check("rsp_data", rsp_data, (ph == 3) ? m_data : 16'd0);
            check("busy", busy, ph != 0);
            check("err_flag", err_flag, m_flag);
            if (ph == 1 || ph == 2) begin
                check("mul_a", mul_a, m_a);
                check("mul_b", mul_b, m_b);
            end
        end
    end

    // One transaction for requester own: grant, response literals, latency from grant cycle.
    task automatic do_one(input int own, input logic [15:0] exp_data, input bit exp_err,
                          input int exp_lat, input int ack_dly, input bit drop,
                          input string nm);
        int t;
        int lat;
        t = 0;
        @(negedge clk);
        while (gnt == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_gnt"}, gnt, (own == 1) ? 2 : 1);
        @(posedge clk);
        #1;
        if (drop) req[own] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (rsp_valid == 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_valid"}, rsp_valid, (own == 1) ? 2 : 1);
        check({nm, "_data"}, rsp_data, exp_data);
        check({nm, "_err"}, rsp_err, exp_err);
        repeat (ack_dly) @(negedge clk);
        check({nm, "_data_held"}, rsp_data, exp_data);
        @(posedge clk);
        #1;
        rsp_ack[own] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ack = 2'b00;
    endtask

    task automatic pulse_reset();
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1;
        req     = 2'b00;
        rsp_ack = 2'b00;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b0;
        chk_en  = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_gnt", gnt, 0);
        check("reset_err_flag", err_flag, 0);

        // Single requester, full-scale operands.
        a0 = 8'hFF; b0 = 8'hFF; mdelay = 5; req = 2'b01;
        do_one(0, 16'hFE01, 1'b0, 6, 0, 1'b1, "ff_x_ff");

        // Tie from reset: requester 0 first, then 1.
        pulse_reset();
        a0 = 8'd3; b0 = 8'd4; a1 = 8'd5; b1 = 8'd6; req = 2'b11;
        do_one(0, 16'd12, 1'b0, 6, 0, 1'b1, "tie_first");
        do_one(1, 16'd30, 1'b0, 6, 0, 1'b1, "tie_second");

        // Multiplier never finishes: abort after TO waiting cycles.
        mdelay = 0; a0 = 8'd9; b0 = 8'd9; req = 2'b01;
        do_one(0, 16'd0, 1'b1, int'(TO) + 1, 0, 1'b1, "timeout");
        check("err_flag_sticky", err_flag, 1);

        // Slow ack with a stray done during the response.
        mdelay = 3; a1 = 8'd7; b1 = 8'd9; req = 2'b10;
        spur_req++;
        do_one(1, 16'd63, 1'b0, 4, 10, 1'b1, "slow_ack");
        check("err_flag_still_set", err_flag, 1);

        // Reset while the multiplier is busy.
        mdelay = 0; a0 = 8'd10; b0 = 8'd10; req = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        reset_a = 1'b1;
        req     = 2'b00;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        @(negedge clk);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_start", mul_start, 0);
        check("mid_reset_valid", rsp_valid, 0);
        check("mid_reset_err_flag", err_flag, 0);
        mdelay = 2; a1 = 8'd11; b1 = 8'd13; req = 2'b10;
        do_one(1, 16'd143, 1'b0, 3, 0, 1'b1, "after_reset");

        // Continuous requests alternate strictly.
        mdelay = 1; a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5; req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            do_one(i % 2, (i % 2 == 1) ? 16'd20 : 16'd6, 1'b0, 2, 0, 1'b0, "alternate");
        end
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
